// File: rtl/fpu_pkg.sv
// Shared definitions for the FP-unit arbiter: FSM states, op-select codes
// and the default watchdog limit.
package fpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    RELEASE
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  localparam int DEFAULT_TIMEOUT = 4096;

endpackage

// File: rtl/fpu_arbiter_if.sv
// Bus between the arbiter and the shared floating-point unit (UnidadePontoFlt).
interface fpu_arbiter_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] fpu_a;
  logic [WIDTH-1:0] fpu_b;
  logic             fpu_multiplicando;
  logic             fpu_start;
  logic [WIDTH-1:0] fpu_s;
  logic             fpu_finish;

  modport master (
    output fpu_a, fpu_b, fpu_multiplicando, fpu_start,
    input  fpu_s, fpu_finish
  );

  modport slave (
    input  fpu_a, fpu_b, fpu_multiplicando, fpu_start,
    output fpu_s, fpu_finish
  );

endinterface

// File: rtl/fpu_rr_arb2.sv
// Two-way round-robin pick: on a tie the requester not served last wins.
module fpu_rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic grant
);

  assign valid = req0 | req1;
  assign grant = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one FP unit between two requesters: round-robin grant, one-cycle
// start strobe, result capture with a done pulse and a timeout watchdog.
module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TO_W    = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             mul0,
  output logic             done0,
  output logic [WIDTH-1:0] result0,
  output logic             err0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             mul1,
  output logic             done1,
  output logic [WIDTH-1:0] result1,
  output logic             err1,
  fpu_arbiter_if.master    fpu,
  output logic             busy
);

  state_t           state;
  state_t           state_nx;
  logic             grant;
  logic             last_grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_mul;
  logic [TO_W-1:0]  count;
  logic             arb_valid;
  logic             arb_grant;
  logic             timed_out;

  fpu_rr_arb2 u_arb (
    .req0      (req0),
    .req1      (req1),
    .last_grant(last_grant),
    .valid     (arb_valid),
    .grant     (arb_grant)
  );

  assign timed_out = (count == TO_W'(TIMEOUT - 1));

  // The FP unit only ever sees the operands latched at grant time.
  assign fpu.fpu_a             = op_a;
  assign fpu.fpu_b             = op_b;
  assign fpu.fpu_multiplicando = op_mul;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    fpu.fpu_start = 1'b0;
    done0         = 1'b0;
    done1         = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE:    if (arb_valid) state_nx = ISSUE;
      ISSUE: begin
        fpu.fpu_start = 1'b1;
        state_nx      = WAIT;
      end
      WAIT:    if (fpu.fpu_finish || timed_out) state_nx = RESP;
      RESP: begin
        done0    = ~grant;
        done1    = grant;
        // A timed-out op has no finish to wait out, so it skips RELEASE.
        state_nx = (grant ? err1 : err0) ? IDLE : RELEASE;
      end
      RELEASE: if (!fpu.fpu_finish) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_mul     <= OP_ADD;
      count      <= '0;
      result0    <= '0;
      result1    <= '0;
      err0       <= 1'b0;
      err1       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (arb_valid) begin
          grant  <= arb_grant;
          op_a   <= arb_grant ? a1 : a0;
          op_b   <= arb_grant ? b1 : b0;
          op_mul <= arb_grant ? mul1 : mul0;
        end
        ISSUE: count <= '0;
        WAIT: begin
          count <= count + TO_W'(1);
          if (fpu.fpu_finish) begin
            if (grant) begin
              result1 <= fpu.fpu_s;
              err1    <= 1'b0;
            end else begin
              result0 <= fpu.fpu_s;
              err0    <= 1'b0;
            end
          end else if (timed_out) begin
            if (grant) begin
              result1 <= '0;
              err1    <= 1'b1;
            end else begin
              result0 <= '0;
              err0    <= 1'b1;
            end
          end
        end
        RESP: last_grant <= grant;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Self-checking bench for fpu_arbiter: an FP-unit stub with configurable
// latency/hold/hang, directed scenarios, and a randomized phase checked by
// a transaction-level reference monitor.
module tb_fpu_arbiter;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 16;
  localparam int TO_W    = 13;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0, req1, mul0, mul1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             done0, done1, err0, err1, busy;
  logic [WIDTH-1:0] result0, result1;

  int checks = 0;
  int failures = 0;

  bit stub_hang = 1'b0;
  bit stub_rand = 1'b0;
  int stub_latency = 3;
  int stub_hold = 1;
  int stub_starts = 0;

  always #5 clk = ~clk;

  fpu_arbiter_if #(.WIDTH(WIDTH)) fpu_bus ();

  fpu_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .mul0(mul0),
    .done0(done0), .result0(result0), .err0(err0),
    .req1(req1), .a1(a1), .b1(b1), .mul1(mul1),
    .done1(done1), .result1(result1), .err1(err1),
    .fpu(fpu_bus.master), .busy(busy)
  );

  // Known IEEE-754 vectors return their true result; anything else gets a
  // deterministic scramble so misrouted operands or results are visible.
  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic m);
    if (a == 32'h3E99999A && b == 32'h3E4CCCCD) return m ? 32'h3D75C28F : 32'h3F000000;
    return (a ^ {b[15:0], b[31:16]}) + (m ? 32'h0101_0101 : 32'h0);
  endfunction

  int          lat_left = 0;
  int          hold_left = 0;
  int          cur_hold = 1;
  logic [31:0] cap_a, cap_b;
  logic        cap_m;

  always @(negedge clk) begin
    if (!rst_n) begin
      fpu_bus.fpu_finish = 1'b0;
      fpu_bus.fpu_s      = '0;
      lat_left           = 0;
      hold_left          = 0;
    end else begin
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) fpu_bus.fpu_finish = 1'b0;
      end else if (lat_left > 0) begin
        lat_left--;
        if (lat_left == 0) begin
          fpu_bus.fpu_finish = 1'b1;
          fpu_bus.fpu_s      = fp_model(cap_a, cap_b, cap_m);
          hold_left          = cur_hold;
        end
      end
      if (fpu_bus.fpu_start) begin
        stub_starts++;
        cap_a = fpu_bus.fpu_a;
        cap_b = fpu_bus.fpu_b;
        cap_m = fpu_bus.fpu_multiplicando;
        if (stub_rand) begin
          lat_left = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
          cur_hold = $urandom_range(1, 3);
        end else begin
          lat_left = stub_hang ? 0 : stub_latency;
          cur_hold = stub_hold;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] av, input logic [31:0] bv, input logic mv);
    @(negedge clk);
    if (idx == 0) begin a0 = av; b0 = bv; mul0 = mv; req0 = 1'b1; end
    else          begin a1 = av; b1 = bv; mul1 = mv; req1 = 1'b1; end
  endtask

  task automatic dropReq(input int idx);
    @(negedge clk);
    if (idx == 0) req0 = 1'b0;
    else          req1 = 1'b0;
  endtask

  task automatic tickCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input int idx, input int budget, output int cyc);
    cyc = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      #1;
      if ((idx == 0) ? done0 : done1) begin
        cyc = n;
        break;
      end
    end
    if (cyc < 0) checkOutput($sformatf("done%0d_wait", idx), 0, 1);
  endtask

  // Transaction-level reference: on every start it decides who should have
  // won from the pending requests and who was served last, then predicts
  // when that requester's done must appear and what it must carry.
  task automatic monitor();
    logic        last_served = 1'b1;
    logic        op_active = 1'b0;
    logic        saw_release = 1'b1;
    logic        winner = 1'b0;
    logic [1:0]  pending;
    logic [31:0] ea, eb;
    logic        em;
    logic        exp_d0, exp_d1;
    int          elapsed = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        op_active   = 1'b0;
        last_served = 1'b1;
        saw_release = 1'b1;
        continue;
      end
      exp_d0 = 1'b0;
      exp_d1 = 1'b0;
      if (fpu_bus.fpu_start) begin
        checkOutput("mon_start_while_idle", op_active, 0);
        checkOutput("mon_release_before_start", saw_release, 1);
        pending = {req1, req0};
        checkOutput("mon_start_has_req", pending != 2'b00, 1);
        winner = (pending == 2'b11) ? ~last_served : pending[1];
        ea = winner ? a1 : a0;
        eb = winner ? b1 : b0;
        em = winner ? mul1 : mul0;
        checkOutput("mon_fpu_ab", {fpu_bus.fpu_a, fpu_bus.fpu_b}, {ea, eb});
        checkOutput("mon_fpu_op", fpu_bus.fpu_multiplicando, em);
        op_active = 1'b1;
        elapsed   = 0;
      end else if (op_active) begin
        elapsed++;
        if (elapsed >= 2 && fpu_bus.fpu_finish) begin
          if (winner) exp_d1 = 1'b1; else exp_d0 = 1'b1;
          checkOutput("mon_result", winner ? result1 : result0, fp_model(ea, eb, em));
          checkOutput("mon_err_clear", winner ? err1 : err0, 0);
          op_active   = 1'b0;
          last_served = winner;
          saw_release = 1'b0;
        end else if (elapsed == TIMEOUT + 1) begin
          if (winner) exp_d1 = 1'b1; else exp_d0 = 1'b1;
          checkOutput("mon_timeout_result", winner ? result1 : result0, 0);
          checkOutput("mon_timeout_err", winner ? err1 : err0, 1);
          op_active   = 1'b0;
          last_served = winner;
          saw_release = 1'b1;
        end else begin
          checkOutput("mon_fpu_hold", {fpu_bus.fpu_a, fpu_bus.fpu_b}, {ea, eb});
          checkOutput("mon_busy", busy, 1);
        end
      end else if (!fpu_bus.fpu_finish) begin
        saw_release = 1'b1;
      end
      checkOutput("mon_done0", done0, exp_d0);
      checkOutput("mon_done1", done1, exp_d1);
    end
  endtask

  initial begin
    int          c;
    int          n;
    int          s0;
    logic        who;
    logic        drained;
    logic [31:0] la, lb;

    req0 = 1'b0; req1 = 1'b0; mul0 = 1'b0; mul1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    fork
      monitor();
      begin
        #300000;
        checkOutput("global_watchdog", 0, 1);
      end
      begin
        tickCycles(3);
        checkOutput("reset_dones", {done0, done1, err0, err1, busy, fpu_bus.fpu_start}, 0);
        checkOutput("reset_results", {result0, result1}, 0);
        checkOutput("reset_fpu_ops", {fpu_bus.fpu_a, fpu_bus.fpu_b}, 0);
        @(negedge clk) rst_n = 1'b1;

        $display("[TB] req0 alone, multiply");
        stub_latency = 3; stub_hold = 1; s0 = stub_starts;
        applyStimulus(0, 32'h3E99999A, 32'h3E4CCCCD, 1'b1);
        waitDone(0, 40, c);
        checkOutput("t1_latency", c, 5);
        checkOutput("t1_result0", result0, 32'h3D75C28F);
        checkOutput("t1_err0", err0, 0);
        dropReq(0);
        tickCycles(4);
        checkOutput("t1_single_start", stub_starts - s0, 1);

        $display("[TB] req1 alone, add");
        applyStimulus(1, 32'h3E99999A, 32'h3E4CCCCD, 1'b0);
        tickCycles(1);
        checkOutput("t2_start", fpu_bus.fpu_start, 1);
        tickCycles(1);
        checkOutput("t2_wait_state", {fpu_bus.fpu_start, fpu_bus.fpu_multiplicando, busy}, 3'b001);
        waitDone(1, 40, c);
        checkOutput("t2_result1", result1, 32'h3F000000);
        checkOutput("t2_result0_kept", result0, 32'h3D75C28F);
        dropReq(1);
        tickCycles(3);

        $display("[TB] both requesting, strict alternation");
        @(negedge clk);
        a0 = $urandom; b0 = $urandom; mul0 = 1'b1; req0 = 1'b1;
        a1 = $urandom; b1 = $urandom; mul1 = 1'b0; req1 = 1'b1;
        for (int op = 0; op < 4; op++) begin
          c = -1;
          for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (done0 || done1) begin c = k; break; end
          end
          checkOutput("t3_done_seen", c >= 0, 1);
          who = done1;
          checkOutput($sformatf("t3_order_%0d", op), who, op % 2);
          @(negedge clk);
          if (op == 3) begin req0 = 1'b0; req1 = 1'b0; end
          else if (who) req1 = 1'b0;
          else          req0 = 1'b0;
          if (op < 3) begin
            @(negedge clk);
            if (who) req1 = 1'b1; else req0 = 1'b1;
          end
        end
        tickCycles(6);

        $display("[TB] level finish held five cycles");
        stub_latency = 2; stub_hold = 5; s0 = stub_starts;
        applyStimulus(0, $urandom, $urandom, 1'b0);
        waitDone(0, 40, c);
        dropReq(0);
        tickCycles(4);
        checkOutput("t4_busy_in_release", busy, 1);
        tickCycles(1);
        checkOutput("t4_idle_after_release", busy, 0);
        tickCycles(5);
        checkOutput("t4_single_start", stub_starts - s0, 1);
        stub_hold = 1;

        $display("[TB] hung FP unit, watchdog");
        stub_hang = 1'b1;
        applyStimulus(0, $urandom, $urandom, 1'b1);
        n = -1;
        for (int k = 0; k < 10; k++) begin
          @(posedge clk);
          #1;
          if (fpu_bus.fpu_start) begin n = 0; break; end
        end
        checkOutput("t5_start_seen", n, 0);
        for (int k = 0; k < 40; k++) begin
          @(posedge clk);
          #1;
          n++;
          if (done0) break;
        end
        checkOutput("t5_timeout_cycles", n, TIMEOUT + 1);
        checkOutput("t5_err0", err0, 1);
        checkOutput("t5_result0", result0, 0);
        dropReq(0);
        stub_hang = 1'b0; stub_latency = 1;
        la = $urandom; lb = $urandom;
        applyStimulus(0, la, lb, 1'b1);
        waitDone(0, 40, c);
        checkOutput("t5_min_latency", c, 3);
        checkOutput("t5_err0_cleared", err0, 0);
        checkOutput("t5_result0", result0, fp_model(la, lb, 1'b1));
        dropReq(0);
        tickCycles(3);

        $display("[TB] reset during WAIT with operand change");
        stub_hang = 1'b1;
        la = $urandom; lb = $urandom;
        applyStimulus(0, la, lb, 1'b0);
        tickCycles(3);
        @(negedge clk) a0 = ~la;
        tickCycles(1);
        checkOutput("t6_fpu_a_latched", fpu_bus.fpu_a, la);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("t6_reset_outputs", {done0, done1, busy, err0, fpu_bus.fpu_start}, 0);
        checkOutput("t6_reset_regs", {result0, fpu_bus.fpu_a}, 0);
        @(negedge clk) req0 = 1'b0;
        tickCycles(2);
        @(negedge clk) rst_n = 1'b1;
        stub_hang = 1'b0; stub_latency = 2;
        tickCycles(5);
        checkOutput("t6_no_done_after_reset", {done0, busy}, 0);
        @(negedge clk);
        a0 = $urandom; b0 = $urandom; req0 = 1'b1;
        a1 = $urandom; b1 = $urandom; req1 = 1'b1;
        waitDone(0, 40, c);
        checkOutput("t6_first_tie_req1_idle", done1, 0);
        dropReq(0);
        waitDone(1, 40, c);
        dropReq(1);
        tickCycles(4);

        $display("[TB] randomized traffic");
        stub_rand = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
          @(negedge clk);
          if (req0) begin
            if (done0) req0 = 1'b0;
          end else if ($urandom_range(0, 2) == 0) begin
            a0 = $urandom; b0 = $urandom; mul0 = 1'($urandom_range(0, 1)); req0 = 1'b1;
          end
          if (req1) begin
            if (done1) req1 = 1'b0;
          end else if ($urandom_range(0, 2) == 0) begin
            a1 = $urandom; b1 = $urandom; mul1 = 1'($urandom_range(0, 1)); req1 = 1'b1;
          end
        end
        drained = 1'b0;
        for (int k = 0; k < 300; k++) begin
          @(negedge clk);
          if (done0) req0 = 1'b0;
          if (done1) req1 = 1'b0;
          if (!req0 && !req1 && !busy) begin drained = 1'b1; break; end
        end
        checkOutput("t7_drain", drained, 1);
        stub_rand = 1'b0;
        tickCycles(3);
      end
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Shares the single floating-point unit (UnidadePontoFlt: a, b, multiplicando, start -> s, finish) between two requesters, e.g. the integer pipeline's FP issue path and a load/convert helper.
- Arbitrates round-robin, drives operands and the op select, issues a one-cycle start, and waits for finish.
- Captures s and returns it to the granted requester with a done pulse.
- Adds a timeout watchdog so a hung FP unit cannot lock the core.

Parameters:
- WIDTH, 32, operand/result width (IEEE-754 single).
- TIMEOUT, 4096, max cycles waited for fpu_finish after start.
- TO_W, 13, timeout counter width; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 request; level, held until done0
- a0, b0  in  WIDTH  requester 0 operands
- mul0  in  1  requester 0 op: 1 = multiply, 0 = add
- done0  out  1  one-cycle pulse: result0/err0 valid
- result0  out  WIDTH  requester 0 result
- err0  out  1  timeout flag, valid with done0
- req1, a1, b1, mul1, done1, result1, err1: same as requester 0, for requester 1
- fpu_a, fpu_b  out  WIDTH  operands to FP unit
- fpu_multiplicando  out  1  op select to FP unit
- fpu_start  out  1  start strobe to FP unit
- fpu_s  in  WIDTH  FP unit result
- fpu_finish  in  1  FP unit completion, level or pulse
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; all outputs 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - Timeout counter = 0.
  - Reset mid-operation abandons the op silently: no done pulse.
- State machine:
  - IDLE: if any req, latch the grant plus that requester's a, b, mul into internal regs.
    - Both requesting: grant the one != last_grant.
    - Go to ISSUE next cycle.
  - ISSUE (1 cycle): fpu_start = 1. fpu_a/fpu_b/fpu_multiplicando driven from the latched regs. Clear counter. Go to WAIT.
  - WAIT: fpu_start = 0; operands held stable. Counter increments each cycle.
    - fpu_finish = 1: capture fpu_s into the granted requester's result register; go to RESP.
    - Counter reaches TIMEOUT-1 without finish: set that requester's err; result = 0; go to RESP.
  - RESP (1 cycle): pulse done of the granted requester only. Update last_grant = grant. Go to RELEASE.
  - RELEASE: wait until fpu_finish = 0, then go to IDLE.
    - A level-style finish cannot satisfy the next op.
    - Err ops skip RELEASE and go directly to IDLE.
- Operand latching: the FP unit sees only the values latched in IDLE. Requester operand changes after grant are ignored.
- Request withdrawn after grant: the op completes; done still pulses; result is written.
- Results hold until the same requester's next done. err clears on that requester's next done.
- Latency, req rising in IDLE at cycle 0:
  - Grant latched at edge 1; fpu_start high cycle 1.
  - Finish seen at cycle k >= 2 gives done at cycle k+1.
  - Next grant no earlier than two cycles after done.
- fpu_finish during IDLE/ISSUE is ignored.
- Fairness: continuous requests from both alternate strictly: 0, 1, 0, 1...

Decomposition:
- Shared package fpu_pkg holds:
  - State encoding constants: IDLE, ISSUE, WAIT, RESP, RELEASE.
  - Op-select constants OP_ADD = 0, OP_MUL = 1.
  - Default TIMEOUT.
- One natural sub-module: fpu_rr_arb2.
  - Combinational 2-way round-robin pick from req0, req1, last_grant.
  - Reused later when a third FP client is added.
- Top holds the FSM, operand/result registers and the watchdog.

Test Plan:
- req0 alone, a0 = 0x3E99999A (0.3), b0 = 0x3E4CCCCD (0.2), mul0 = 1, real FP unit -> single fpu_start pulse; done0 once; result0 = 0x3D75C28F (0.06, FP model match); err0 = 0; done1 never.
- req1 alone, same operands, mul1 = 0 -> fpu_multiplicando = 0 during WAIT; result1 = 0x3F000000 (0.5).
- req0 and req1 rise same cycle, held high for 4 ops -> grant order 0, 1, 0, 1; each done follows its own finish; results not cross-written.
- FP stub holding fpu_finish high 5 cycles -> FSM stays in RELEASE until finish low; exactly one done; no spurious second start.
- FP stub never asserts finish, TIMEOUT = 16 -> done0 with err0 = 1 exactly 17 cycles after fpu_start; then a normal op returns err0 = 0.
- rst_n low during WAIT, and a0 changed after grant -> reset: outputs 0, no done, busy = 0. Operand change: fpu_a keeps the latched value.
